// File: rtl/music_pkg.sv
// Shared constants and FSM encoding for the playback audio stage.
package music_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2,
      WAIT = 2'd3
   } state_e;

   localparam logic [31:0] DEF_AMPLITUDE   = 32'h0800_0000;
   localparam logic [31:0] DEF_NOTE_CYCLES = 32'd25_000_000;
   localparam logic [31:0] DEF_GAP_CYCLES  = 32'd2_500_000;
   localparam logic [31:0] DEF_LOAD_WAIT   = 32'd2;

endpackage

// File: rtl/note_tone_gen_if.sv
// Controller/datapath/codec-facing signals of the tone generator.
interface note_tone_gen_if;
   logic        play_en;
   logic [31:0] half_period;
   logic        audio_ready;
   logic        audio_valid;
   logic [31:0] sample_left;
   logic [31:0] sample_right;
   logic        next_note_en;
   logic        busy;

   modport master (
      output play_en, half_period, audio_ready,
      input  audio_valid, sample_left, sample_right, next_note_en, busy
   );

   modport slave (
      input  play_en, half_period, audio_ready,
      output audio_valid, sample_left, sample_right, next_note_en, busy
   );
endinterface

// File: rtl/square_osc.sv
// Square-wave oscillator: half-period counter and polarity flag.
module square_osc
   import music_pkg::*;
#(
   parameter logic [31:0] AMPLITUDE = DEF_AMPLITUDE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        run_i,
   input  logic [31:0] half_period_i,
   output logic [31:0] wave_o
);

   logic [31:0] period_q, period_d;
   logic [31:0] phase_q, phase_d;
   logic        pol_q, pol_d;

   always_comb begin
      period_d = period_q;
      phase_d  = phase_q;
      pol_d    = pol_q;
      if (load_i) begin
         period_d = half_period_i;
         phase_d  = '0;
         pol_d    = 1'b1;
      end else if (run_i && (period_q != '0)) begin
         if (phase_q == period_q - 32'd1) begin
            phase_d = '0;
            pol_d   = ~pol_q;
         end else begin
            phase_d = phase_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period_q <= '0;
         phase_q  <= '0;
         pol_q    <= 1'b0;
      end else begin
         period_q <= period_d;
         phase_q  <= phase_d;
         pol_q    <= pol_d;
      end
   end

   // A zero period is a rest: silent, with phase and polarity frozen.
   always_comb begin
      wave_o = '0;
      if (run_i && (period_q != '0))
         wave_o = pol_q ? AMPLITUDE : (32'd0 - AMPLITUDE);
   end

endmodule

// File: rtl/note_tone_gen.sv
// Playback tone stage: note/gap timing FSM, oscillator control and the
// valid/ready stereo sample register feeding the audio codec.
module note_tone_gen
   import music_pkg::*;
#(
   parameter logic [31:0] AMPLITUDE   = DEF_AMPLITUDE,
   parameter logic [31:0] NOTE_CYCLES = DEF_NOTE_CYCLES,
   parameter logic [31:0] GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter logic [31:0] LOAD_WAIT   = DEF_LOAD_WAIT
) (
   input  logic             clk,
   input  logic             reset,
   note_tone_gen_if.slave   bus
);

   state_e      state_q, state_d;
   logic [31:0] dur_q, dur_d;
   logic        next_q, next_d;
   logic        valid_q, valid_d;
   logic [31:0] sample_q, sample_d;
   logic        osc_load;
   logic [31:0] wave;

   square_osc #(
      .AMPLITUDE (AMPLITUDE)
   ) u_osc (
      .clk           (clk),
      .reset         (reset),
      .load_i        (osc_load),
      .run_i         (state_q == PLAY),
      .half_period_i (bus.half_period),
      .wave_o        (wave)
   );

   always_comb begin
      state_d  = state_q;
      dur_d    = dur_q;
      next_d   = 1'b0;
      osc_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            dur_d = '0;
            if (bus.play_en) begin
               state_d  = PLAY;
               dur_d    = NOTE_CYCLES - 32'd1;
               osc_load = 1'b1;
            end
         end
         PLAY: begin
            if (dur_q == '0) begin
               state_d = GAP;
               dur_d   = GAP_CYCLES - 32'd1;
            end else begin
               dur_d = dur_q - 32'd1;
            end
         end
         GAP: begin
            if (dur_q == '0) begin
               state_d = WAIT;
               dur_d   = LOAD_WAIT - 32'd1;
               next_d  = 1'b1;
            end else begin
               dur_d = dur_q - 32'd1;
            end
         end
         WAIT: begin
            if (dur_q == '0) begin
               state_d  = PLAY;
               dur_d    = NOTE_CYCLES - 32'd1;
               osc_load = 1'b1;
            end else begin
               dur_d = dur_q - 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Leaving playback wins over any timer expiry on the same edge.
      if ((state_q != IDLE) && !bus.play_en) begin
         state_d  = IDLE;
         dur_d    = '0;
         next_d   = 1'b0;
         osc_load = 1'b0;
      end
   end

   always_comb begin
      valid_d  = (state_q != IDLE) && bus.play_en;
      sample_d = sample_q;
      if (state_d == IDLE)
         sample_d = '0;
      else if (!valid_q || bus.audio_ready)
         sample_d = wave;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         dur_q    <= '0;
         next_q   <= 1'b0;
         valid_q  <= 1'b0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         dur_q    <= dur_d;
         next_q   <= next_d;
         valid_q  <= valid_d;
         sample_q <= sample_d;
      end
   end

   assign bus.audio_valid  = valid_q;
   assign bus.sample_left  = sample_q;
   assign bus.sample_right = sample_q;
   assign bus.next_note_en = next_q;
   assign bus.busy         = (state_q != IDLE);

endmodule
